// File: rtl/bus_slave.sv
// bus_slave: simple request/acknowledge register-file slave.
// A four-phase WB/RB handshake reaches a 2**ADDR_BITS deep register file
// through an IDLE -> WAIT -> ACK state machine with fully registered outputs.
// Optional feature: define BUS_SLAVE_WAIT_EN to make WAIT last WAIT_STATES
// cycles (minimum one); otherwise WAIT always lasts exactly one cycle.
module bus_slave #(
  parameter int                   BUS_WIDTH   = 8,
  parameter int                   ADDR_BITS   = 2,
  parameter logic [BUS_WIDTH-1:0] BASE_ADDR   = 8'h00,
  parameter int                   WAIT_STATES = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 WB,
  input  logic                 RB,
  input  logic [BUS_WIDTH-1:0] address,
  input  logic [BUS_WIDTH-1:0] wdata,
  output logic [BUS_WIDTH-1:0] rdata,
  output logic                 Ack,
  output logic                 Err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } state_t;

  state_t                 state;
  logic                   req_write;  // type of the request being served
  logic                   dual_q;     // both requests were high last IDLE cycle
  logic [BUS_WIDTH-1:0]   regs [2**ADDR_BITS];

  logic                   sel;
  logic                   held;
  logic [ADDR_BITS-1:0]   idx;
  logic                   wait_done;

  // Decode: block select on the upper address bits, index on the lower ones.
  assign sel  = (address[BUS_WIDTH-1:ADDR_BITS] == BASE_ADDR[BUS_WIDTH-1:ADDR_BITS]);
  assign idx  = address[ADDR_BITS-1:0];

  // The originating request counts as held only while it alone stays high;
  // a swap of request type is treated as a drop.
  assign held = req_write ? (WB && !RB) : (RB && !WB);

`ifdef BUS_SLAVE_WAIT_EN
  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

  logic [CNT_W-1:0] cnt;

  // WAIT_STATES of zero still spends one cycle in WAIT.
  assign wait_done = (cnt == CNT_LAST);
`else
  assign wait_done = 1'b1;
`endif

  // Control FSM, register file and all registered outputs.
  // NOTE: every register here is assigned with <= so all state updates use
  // the values sampled at the same clock edge, regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      req_write <= 1'b0;
      dual_q    <= 1'b0;
      Ack       <= 1'b0;
      Err       <= 1'b0;
      rdata     <= '0;
      // NOTE: the register file is cleared by reset because software relies
      // on reading zeros after reset; a plain RAM array would not be reset.
      regs      <= '{default: '0};
`ifdef BUS_SLAVE_WAIT_EN
      cnt       <= '0;
`endif
    end else begin
      Err    <= 1'b0;
      dual_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          Ack <= 1'b0;
          if (sel && WB && RB) begin
            // Pulse once per conflicting request, however long it is held.
            Err    <= !dual_q;
            dual_q <= 1'b1;
          end else if (sel && (WB ^ RB)) begin
            state     <= ST_WAIT;
            req_write <= WB;
`ifdef BUS_SLAVE_WAIT_EN
            cnt       <= '0;
`endif
          end
        end
        ST_WAIT: begin
          if (!held) begin
            state <= ST_IDLE;
          end else if (wait_done) begin
            state <= ST_ACK;
            Ack   <= 1'b1;
            if (req_write) begin
              regs[idx] <= wdata;
            end else begin
              rdata <= regs[idx];
            end
          end else begin
`ifdef BUS_SLAVE_WAIT_EN
            cnt <= cnt + 1'b1;
`endif
          end
        end
        ST_ACK: begin
          if (!held) begin
            Ack   <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          Ack   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_slave.sv
// Self-checking bench for bus_slave. The reference model is transaction
// level: a four-entry memory image plus the last value read, with expected
// handshake timing derived from the number of WAIT cycles.
module tb_bus_slave;

`ifdef BUS_SLAVE_WAIT_EN
  localparam int WCYC = 3;  // WAIT_STATES = 3 below
`else
  localparam int WCYC = 1;
`endif

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       WB      = 1'b0;
  logic       RB      = 1'b0;
  logic [7:0] address = '0;
  logic [7:0] wdata   = '0;
  logic [7:0] rdata;
  logic       Ack;
  logic       Err;

  int         n_vec = 0;
  int         n_bad = 0;

  logic [7:0] mem [4];
  logic [7:0] last_rd;

  bus_slave #(
    .BUS_WIDTH  (8),
    .ADDR_BITS  (2),
    .BASE_ADDR  (8'h00),
    .WAIT_STATES(3)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .WB     (WB),
    .RB     (RB),
    .address(address),
    .wdata  (wdata),
    .rdata  (rdata),
    .Ack    (Ack),
    .Err    (Err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic ack, input logic err);
    check({tag, ".ack"}, 32'(Ack), 32'(ack));
    check({tag, ".err"}, 32'(Err), 32'(err));
    check({tag, ".rdata"}, 32'(rdata), 32'(last_rd));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mem[i] = 8'h00;
    last_rd = 8'h00;
  endtask

  task automatic idle(input int n);
    WB = 1'b0;
    RB = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      expect_out("idle", 1'b0, 1'b0);
    end
  endtask

  // Complete selected access. With swap, the drop of WB coincides with RB
  // rising on next_addr; the caller then continues with that read.
  task automatic access(input bit wr, input logic [7:0] addr, input logic [7:0] data,
                        input int hold, input bit swap, input logic [7:0] next_addr);
    int idx;
    idx     = int'(addr[1:0]);
    WB      = wr;
    RB      = !wr;
    address = addr;
    wdata   = data;
    tick();
    expect_out("accept", 1'b0, 1'b0);
    for (int k = 1; k < WCYC; k++) begin
      tick();
      expect_out("wait", 1'b0, 1'b0);
    end
    tick();
    if (wr) mem[idx] = data;
    else    last_rd  = mem[idx];
    expect_out(wr ? "wr_ack_rise" : "rd_ack_rise", 1'b1, 1'b0);
    for (int k = 0; k < hold; k++) begin
      tick();
      expect_out("ack_hold", 1'b1, 1'b0);
    end
    if (swap) begin
      WB      = 1'b0;
      RB      = 1'b1;
      address = next_addr;
    end else begin
      WB = 1'b0;
      RB = 1'b0;
    end
    tick();
    expect_out("ack_fall", 1'b0, 1'b0);
  endtask

  // Request dropped after d cycles (1..WCYC): no Ack, no write.
  task automatic abort_access(input bit wr, input logic [7:0] addr, input logic [7:0] data,
                              input int d);
    WB      = wr;
    RB      = !wr;
    address = addr;
    wdata   = data;
    for (int k = 0; k < d; k++) begin
      tick();
      expect_out("abort_wait", 1'b0, 1'b0);
    end
    WB = 1'b0;
    RB = 1'b0;
    tick();
    expect_out("abort_drop", 1'b0, 1'b0);
  endtask

  task automatic dual_req(input logic [7:0] addr, input int h);
    WB      = 1'b1;
    RB      = 1'b1;
    address = addr;
    wdata   = 8'hEE;
    tick();
    expect_out("dual_err", 1'b0, 1'b1);
    for (int k = 1; k < h; k++) begin
      tick();
      expect_out("dual_hold", 1'b0, 1'b0);
    end
    WB = 1'b0;
    RB = 1'b0;
    tick();
    expect_out("dual_drop", 1'b0, 1'b0);
  endtask

  task automatic unsel_req(input bit wr, input logic [7:0] addr, input int n);
    WB      = wr;
    RB      = !wr;
    address = addr;
    wdata   = 8'hC3;
    for (int k = 0; k < n; k++) begin
      tick();
      expect_out("unsel", 1'b0, 1'b0);
    end
    WB = 1'b0;
    RB = 1'b0;
    tick();
    expect_out("unsel_drop", 1'b0, 1'b0);
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < 4; i++) begin
      access(1'b0, 8'(i), 8'h00, 0, 1'b0, 8'h00);
      check({tag, ".reg"}, 32'(rdata), 32'(mem[i]));
    end
  endtask

  initial begin
    model_reset();

    // Reset held low for two cycles, then read every register.
    reset_n = 1'b0;
    tick();
    expect_out("reset1", 1'b0, 1'b0);
    tick();
    expect_out("reset2", 1'b0, 1'b0);
    reset_n = 1'b1;
    read_all("post_reset");

    // Write then read back at 8'h01.
    access(1'b1, 8'h01, 8'hAA, 2, 1'b0, 8'h00);
    access(1'b0, 8'h01, 8'h00, 3, 1'b0, 8'h00);
    check("rd_01", 32'(rdata), 32'h0000_00AA);

    // Unselected address held for 10 cycles.
    unsel_req(1'b1, 8'h05, 10);

    // Conflicting request at 8'h02, held three cycles.
    dual_req(8'h02, 3);
    read_all("after_dual");

    // Aborted write then completed write at 8'h03.
    abort_access(1'b1, 8'h03, 8'h55, (WCYC < 2) ? WCYC : 2);
    access(1'b0, 8'h03, 8'h00, 0, 1'b0, 8'h00);
    check("abort_no_write", 32'(rdata), 32'h0);
    access(1'b1, 8'h03, 8'h55, 1, 1'b0, 8'h00);
    access(1'b0, 8'h03, 8'h00, 0, 1'b0, 8'h00);
    check("rd_03", 32'(rdata), 32'h0000_0055);

    // Request type swaps while in ACK: write drop + read rise together.
    access(1'b1, 8'h00, 8'h3C, 1, 1'b1, 8'h00);
    access(1'b0, 8'h00, 8'h00, 1, 1'b0, 8'h00);
    check("swap_rd", 32'(rdata), 32'h0000_003C);

    // Reset while in ACK of a write of 8'h33 to 8'h02.
    WB      = 1'b1;
    RB      = 1'b0;
    address = 8'h02;
    wdata   = 8'h33;
    for (int k = 0; k < WCYC; k++) tick();
    tick();
    check("pre_reset_ack", 32'(Ack), 32'h1);
    reset_n = 1'b0;
    tick();
    model_reset();
    expect_out("mid_ack_reset", 1'b0, 1'b0);
    reset_n = 1'b1;
    WB      = 1'b0;
    // First edge with reset released accepts the request.
    access(1'b0, 8'h02, 8'h00, 0, 1'b0, 8'h00);
    check("rd_02_after_reset", 32'(rdata), 32'h0);

    // Randomized traffic against the model.
    for (int it = 0; it < 80; it++) begin
      int         op;
      logic [7:0] a;
      logic [7:0] d;
      op = int'($urandom_range(0, 6));
      a  = {6'b0, 2'($urandom_range(0, 3))};
      d  = 8'($urandom());
      case (op)
        0, 1: access(1'b1, a, d, int'($urandom_range(0, 3)), 1'b0, 8'h00);
        2:    access(1'b0, a, d, int'($urandom_range(0, 3)), 1'b0, 8'h00);
        3:    abort_access(1'($urandom_range(0, 1)), a, d, int'($urandom_range(1, WCYC)));
        4:    dual_req(a, int'($urandom_range(1, 4)));
        5:    unsel_req(1'($urandom_range(0, 1)),
                        {6'($urandom_range(1, 63)), a[1:0]}, int'($urandom_range(1, 5)));
        default: begin
          logic [7:0] na;
          na = {6'b0, 2'($urandom_range(0, 3))};
          access(1'b1, a, d, int'($urandom_range(0, 2)), 1'b1, na);
          access(1'b0, na, 8'h00, int'($urandom_range(0, 2)), 1'b0, 8'h00);
        end
      endcase
      idle(int'($urandom_range(0, 2)));
    end
    read_all("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
